// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI4 write scheduler: AW arbitration, W steering in AW order, B routing.
// Define AXI_WR_ARB_STRICT_PRIO_EN to make requester 0 always win instead of round-robin.
module axi_wr_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [1:0]          REQ_VALID,
  output logic [1:0]          REQ_READY,
  input  logic [2*ADDR_W-1:0] REQ_ADDR,
  input  logic [15:0]         REQ_LEN,
  input  logic [2*DATA_W-1:0] REQ_WDATA,
  input  logic [1:0]          REQ_WVALID,
  output logic [1:0]          REQ_WREADY,
  output logic [1:0]          REQ_DONE,
  output logic [1:0]          REQ_RESP,
  output logic                ERR_BID,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  output logic [3:0]          M_AXI_AWID,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  output logic                M_AXI_WLAST,
  input  logic                M_AXI_WREADY,
  input  logic                M_AXI_BVALID,
  input  logic [3:0]          M_AXI_BID,
  input  logic [1:0]          M_AXI_BRESP,
  output logic                M_AXI_BREADY
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUTSTANDING);

  typedef enum logic {W_IDLE, W_BURST} w_state_t;

  w_state_t w_state_q, w_next;

  logic [1:0]        req_ready_q;
  logic              awvalid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [7:0]        awlen_q;
  logic              awid_q;
  logic [OW-1:0]     outs_q;
  logic [OW-1:0]     fcnt_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [8:0]        fifo_q [MAX_OUTSTANDING];
  logic [8:0]        head;
  logic [7:0]        beat_q, len_q;
  logic              owner_q;
  logic [1:0]        done_q;
  logic [1:0]        resp_q;
  logic              err_q;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       can_grant;
  logic       aw_hs, b_hs, push, pop;
  logic       wvalid, wlast;
  logic [DATA_W-1:0] wdata;
  logic [1:0] req_wready;

`ifndef AXI_WR_ARB_STRICT_PRIO_EN
  logic last_q;
`endif

  assign aw_hs  = awvalid_q & M_AXI_AWREADY;
  assign b_hs   = M_AXI_BVALID;
  assign push   = |gnt;
  assign gnt_id = gnt[1];
  assign head   = fifo_q[rd_ptr_q];

  // Pick one requester when the AW slot, credit and order FIFO allow it
  always_comb begin
    can_grant = !awvalid_q && (outs_q < MAX_C) && (fcnt_q != MAX_C);
    gnt       = 2'b00;
`ifdef AXI_WR_ARB_STRICT_PRIO_EN
    if (REQ_VALID[0])      gnt = 2'b01;
    else if (REQ_VALID[1]) gnt = 2'b10;
`else
    if (REQ_VALID == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
    else                    gnt = REQ_VALID;
`endif
    if (!can_grant) gnt = 2'b00;
  end

  // Register the granted command onto AW and hold it until AWREADY
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      req_ready_q <= 2'b00;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awid_q      <= 1'b0;
    end else begin
      req_ready_q <= gnt;
      if (push) begin
        awvalid_q <= 1'b1;
        awaddr_q  <= gnt_id ? REQ_ADDR[2*ADDR_W-1:ADDR_W]
                            : REQ_ADDR[ADDR_W-1:0];
        awlen_q   <= gnt_id ? REQ_LEN[15:8] : REQ_LEN[7:0];
        awid_q    <= gnt_id;
      end else if (aw_hs) begin
        awvalid_q <= 1'b0;
      end
    end
  end

`ifndef AXI_WR_ARB_STRICT_PRIO_EN
  // Remember the last winner so the other requester is favoured next
  always_ff @(posedge ACLK) begin
    if (!ARESETn)  last_q <= 1'b1;
    else if (push) last_q <= gnt_id;
  end
`endif

  // Outstanding-write credit: AW adds one, B removes one
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      outs_q <= '0;
    end else if (aw_hs && !b_hs) begin
      outs_q <= outs_q + OW'(1);
    end else if (!aw_hs && b_hs && outs_q != '0) begin
      outs_q <= outs_q - OW'(1);
    end
  end

  // Order FIFO storage: {owner, LEN} per granted burst
  always_ff @(posedge ACLK) begin
    if (push) fifo_q[wr_ptr_q] <= {gnt_id, (gnt_id ? REQ_LEN[15:8] : REQ_LEN[7:0])};
  end

  // Order FIFO pointers and fill count
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      fcnt_q <= fcnt_q + OW'(1);
      else if (!push && pop) fcnt_q <= fcnt_q - OW'(1);
    end
  end

  // W FSM state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) w_state_q <= W_IDLE;
    else          w_state_q <= w_next;
  end

  // W FSM next state and owner passthrough of the data stream
  always_comb begin
    w_next     = w_state_q;
    pop        = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    wdata      = '0;
    req_wready = 2'b00;
    unique case (w_state_q)
      W_IDLE: begin
        if (fcnt_q != '0) begin
          pop    = 1'b1;
          w_next = W_BURST;
        end
      end
      W_BURST: begin
        wdata = owner_q ? REQ_WDATA[2*DATA_W-1:DATA_W]
                        : REQ_WDATA[DATA_W-1:0];
        wvalid = REQ_WVALID[owner_q];
        wlast  = (beat_q == len_q);
        req_wready[owner_q] = M_AXI_WREADY;
        if (wvalid && M_AXI_WREADY && wlast) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Burst bookkeeping: latch owner/LEN at pop, count completed beats
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      beat_q  <= '0;
      len_q   <= '0;
      owner_q <= 1'b0;
    end else if (pop) begin
      beat_q  <= '0;
      len_q   <= head[7:0];
      owner_q <= head[8];
    end else if (wvalid && M_AXI_WREADY && !wlast) begin
      beat_q  <= beat_q + 8'd1;
    end
  end

  // Route each B response back to its requester by BID
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      done_q <= 2'b00;
      resp_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      done_q <= 2'b00;
      resp_q <= 2'b00;
      if (b_hs) begin
        if (M_AXI_BID == 4'd0) begin
          done_q <= 2'b01;
          resp_q <= M_AXI_BRESP;
        end else if (M_AXI_BID == 4'd1) begin
          done_q <= 2'b10;
          resp_q <= M_AXI_BRESP;
        end else begin
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign REQ_READY     = req_ready_q;
  assign REQ_WREADY    = req_wready;
  assign REQ_DONE      = done_q;
  assign REQ_RESP      = resp_q;
  assign ERR_BID       = err_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWID    = {3'b000, awid_q};
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = 3'($clog2(DATA_W / 8));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_WLAST   = wlast;
  assign M_AXI_BREADY  = 1'b1;

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-requester write scheduler in front of the single AXI4 write master port (AW/W/B) used by the outstanding-burst test system. It arbitrates burst commands onto AW, steers each requester's data stream onto W in AW issue order, generates WLAST, enforces an outstanding-write limit, and routes each B response back to its requester by BID.

## Interface
- MAX_OUTSTANDING, 4: max AW handshakes without a matching B; also the depth of the W-order FIFO (power of 2, 2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width. WSTRB is all ones.
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous, active-low reset.
- REQ_VALID  in  2  per-requester burst command valid; bit i = requester i.
- REQ_READY  out  2  command accepted when VALID&READY.
- REQ_ADDR  in  2*ADDR_W  start address; requester i at bits [i*ADDR_W +: ADDR_W].
- REQ_LEN  in  16  AXI LEN (beats-1); requester i at [i*8 +: 8].
- REQ_WDATA  in  2*DATA_W  write data per requester.
- REQ_WVALID  in  2  data valid.
- REQ_WREADY  out  2  data beat consumed.
- REQ_DONE  out  2  one-cycle pulse per B response for that requester.
- REQ_RESP  out  2  BRESP for the DONE pulse; shared, valid only with DONE.
- ERR_BID  out  1  sticky: a B arrived with BID not 0 or 1.
- M_AXI_AW*  out  AWADDR ADDR_W, AWVALID 1, AWID 4, AWLEN 8, AWSIZE 3, AWBURST 2; AWREADY in 1.
- M_AXI_W*  out  WDATA DATA_W, WSTRB DATA_W/8, WVALID 1, WLAST 1; WREADY in 1.
- M_AXI_B*  BVALID in 1, BID in 4, BRESP in 2; BREADY out 1.

## Operation
- Reset values: AWVALID=0, AWADDR=0, AWID=0, AWLEN=0, AWSIZE=3'b010, AWBURST=2'b01, WVALID=0, WLAST=0, BREADY=1, REQ_READY=0, REQ_WREADY=0, REQ_DONE=0, REQ_RESP=0, ERR_BID=0. The outstanding counter, W-order FIFO and round-robin pointer clear.
- AW arbitration: a grant is possible when AWVALID=0, outstanding<MAX_OUTSTANDING and the order FIFO is not full. Among the asserted REQ_VALID bits, round-robin picks one, starting from the requester after the last grant (after reset, requester 0 has priority).
- On grant: REQ_READY[i] pulses for 1 cycle. AWADDR, AWLEN and AWID=i are registered and AWVALID=1 the next cycle. {i, LEN} is pushed into the order FIFO.
- AWVALID holds with stable fields until AWREADY. The cycle after a handshake has AWVALID=0, so at most one AW is issued every 2 cycles.
- Outstanding counter (width $clog2(MAX_OUTSTANDING+1)): +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle.
- W FSM: W_IDLE -> W_BURST when the FIFO is non-empty. It pops the head, loads the beat counter with 0, latches owner i and LEN.
  - In W_BURST, WDATA=REQ_WDATA[i], WVALID=REQ_WVALID[i] and REQ_WREADY[i]=WREADY, all combinational passthrough.
  - WLAST=1 when beat counter==LEN. A beat completes on WVALID&WREADY.
  - The last beat returns the FSM to W_IDLE. A back-to-back head entry starts the next cycle.
- W may begin before its AW handshake, since the entry is pushed at grant. This is AXI-legal. The slave must tolerate W-before-AW.
- B: BREADY is held at 1. On BVALID with BID==i (i in {0,1}), REQ_DONE[i]=1 and REQ_RESP=BRESP the next cycle. Any other BID still decrements the counter and sets ERR_BID, which clears only on reset.

## Timing
- REQ_VALID to AWVALID: 2 cycles (grant cycle + register) when idle.
- FIFO head to first W beat presented: 1 cycle.
- Boundary conditions:
  - Outstanding==MAX_OUTSTANDING: no REQ_READY until a B handshake. The grant may occur in the cycle after that B.
  - LEN=0: the single beat carries WLAST=1.
  - A REQ_VALID deasserted before grant is legal; no effect.
  - B arriving in the same cycle as a grant: the grant decision uses the pre-update count.
  - Reset mid-burst: all state drops immediately. In-flight transactions are abandoned, with no completion pulses.

## Configuration
- AXI_WR_ARB_STRICT_PRIO_EN defined: requester 0 always wins when both REQ_VALID bits are set, and the round-robin pointer is removed.
- Undefined: round-robin as above.

## Test plan
- Single requester 0, LEN=3, ADDR=0x100, slave always ready -> AW with ID 0, 4 W beats with WLAST on the 4th, one REQ_DONE[0] with RESP=0.
- Both requesters valid continuously, LEN=1 -> grants alternate 0,1,0,1 and W bursts follow AW order. Under STRICT_PRIO_EN, all grants go to 0 while it stays valid.
- BVALID held low, 6 commands queued -> exactly 4 AW handshakes, REQ_READY stalls. One B releases exactly one more grant.
- AW handshake and B handshake in the same cycle at outstanding=2 -> counter stays 2.
- B with BID=5 -> ERR_BID=1 stays set, no REQ_DONE, outstanding decrements.
- ARESETn low during beat 2 of a LEN=3 burst -> next cycle all outputs are at reset values and the FIFO is empty.
